sll_pipe: RTL and testbench
===========================

// Module: sll_pipe
// PURPOSE
//  Two-stage pipelined logical-left barrel shifter with valid/ready handshakes on both sides.
//  It is the left-direction counterpart of the combinational right shifter and feeds the execute-stage shift path.
//  It accepts one operand per cycle and returns results in order after 2 cycles when not stalled.
//  Back-pressure propagates upstream through the ready chain without dropping or duplicating results.
// PARAMETERS
//  OPERAND_WIDTH  16  data width in bits; must equal 2**SHAMT_WIDTH
//  SHAMT_WIDTH    4   shift-amount width; must be even (half per stage)
// PORTS
//  clk       in   1              clock, rising edge
//  rst       in   1              reset, asynchronous, active-high
//  InBS      in   OPERAND_WIDTH  operand to shift
//  ShAmt     in   SHAMT_WIDTH    left shift amount, 0..2**SHAMT_WIDTH-1
//  InValid   in   1              InBS/ShAmt valid this cycle
//  InReady   out  1              block accepts input this cycle (transfer = InValid & InReady)
//  OutBS     out  OPERAND_WIDTH  shifted result (registered)
//  OutValid  out  1              OutBS valid
//  OutReady  in   1              consumer accepts OutBS (transfer = OutValid & OutReady)
// BEHAVIOUR
//  - Stage 1 register (s1): applies ShAmt[SHAMT_WIDTH/2-1:0] (shifts by 1 and 2 at default widths).
//    It stores the partial result, ShAmt[SHAMT_WIDTH-1:SHAMT_WIDTH/2], and s1_valid.
//  - Stage 2 register (s2): applies the stored upper shift bits (shifts by 4 and 8 at default widths).
//    It drives OutBS and OutValid directly from flops.
//  - Shift rule: zeros fill the LSBs and bits shifted past the MSB are discarded.
//    ShAmt=0 passes the operand through unchanged.
//  - Advance: s2_adv = !s2_valid | OutReady;  s1_adv = !s1_valid | s2_adv;  InReady = s1_adv & !rst.
//  - s1 loads on InValid&InReady. If InValid=0 while s1_adv=1, s1_valid clears.
//  - s2 loads from s1 when s2_adv=1 (s2_valid <= s1_valid).
//    s2 data is held unchanged while OutValid & !OutReady.
//  - Latency: input accepted at edge N -> OutValid high after edge N+2 when no stall.
//  - Throughput: 1 result/cycle with OutReady held high.
//  - Full: both stages valid & OutReady=0 -> InReady=0. Stages hold and nothing is overwritten.
//  - Simultaneous accept in and out while full: all three transfers occur in the same cycle and the pipe shifts by one.
//  - OutValid must not drop until its result is accepted. Order is strictly FIFO.
//  - Reset (async, any time incl. mid-flight):
//    s1_valid=0, s2_valid=0, OutValid=0, OutBS=0, stored shift bits=0. In-flight operands are discarded.
//    InReady=0 while rst is high and becomes 1 in the first cycle after release.
//  - No state machine beyond the two valid bits: {s1_valid,s2_valid} = EMPTY/ONE/TWO occupancy.
// CONFIGURATION
//  - SLL_PIPE_ROT_EN defined: adds input port Rot (1 bit), sampled with InBS and carried in s1.
//    Rot=1 rotates left: bits leaving the MSB re-enter at the LSB in both stages.
//    Rot=0 performs the logical left shift.
//  - SLL_PIPE_ROT_EN undefined: Rot port is absent and the block performs the logical left shift only.
// TESTING
//  1. InBS=0x0001 ShAmt=15, OutReady=1 -> OutBS=0x8000, OutValid 2 cycles after accept.
//  2. InBS=0xABCD ShAmt=4 then 0x1234 ShAmt=0 back-to-back -> 0xBCD0 then 0x1234 on consecutive cycles.
//  3. OutReady=0, feed 3 operands -> InReady low after 2 accepted.
//     Then OutReady=1 -> outputs in order with OutBS stable during the stall, then the 3rd result.
//  4. Assert rst with 2 operands in flight -> OutValid=0 and OutBS=0 immediately (async).
//     No stale result after release, and InReady=1 on the first cycle after release.
//  5. Sweep ShAmt 0..15 on 0xFFFF -> OutBS = 0xFFFF<<ShAmt (e.g. ShAmt=8 -> 0xFF00).
//  6. SLL_PIPE_ROT_EN defined: 0x8001 ShAmt=1 Rot=1 -> 0x0003; Rot=0 -> 0x0002.
//     Macro undefined: 0x8001 ShAmt=1 -> 0x0002.

Source files
------------

// File: rtl/sll_pipe_if.sv
// Purpose : handshake bundle for sll_pipe (operand/shift-amount in, shifted result out).
// Ports   : InBS/ShAmt/InValid/InReady on the upstream side, OutBS/OutValid/OutReady downstream;
//           Rot is present only when SLL_PIPE_ROT_EN is defined. master = driver/consumer, slave = shifter.
interface sll_pipe_if #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
);
    logic [OPERAND_WIDTH-1:0] InBS;
    logic [SHAMT_WIDTH-1:0]   ShAmt;
    logic                     InValid;
    logic                     InReady;
    logic [OPERAND_WIDTH-1:0] OutBS;
    logic                     OutValid;
    logic                     OutReady;
`ifdef SLL_PIPE_ROT_EN
    logic                     Rot;
`endif

    modport master (
`ifdef SLL_PIPE_ROT_EN
        output Rot,
`endif
        output InBS,
        output ShAmt,
        output InValid,
        input  InReady,
        input  OutBS,
        input  OutValid,
        output OutReady
    );

    modport slave (
`ifdef SLL_PIPE_ROT_EN
        input  Rot,
`endif
        input  InBS,
        input  ShAmt,
        input  InValid,
        output InReady,
        output OutBS,
        output OutValid,
        input  OutReady
    );
endinterface

// File: rtl/sll_pipe.sv
// Purpose : two-stage logical-left barrel shifter (optional rotate when SLL_PIPE_ROT_EN is defined).
// Latency : 2 cycles from input transfer to OutValid; 1 result/cycle sustained.
// Backpressure: OutReady low stalls s2, then s1; InReady drops only when both stages are full.
// Ports   : clk, rst (async active-high), io (sll_pipe_if.slave: InBS, ShAmt, InValid, InReady,
//           OutBS, OutValid, OutReady, and Rot with SLL_PIPE_ROT_EN).
module sll_pipe #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    sll_pipe_if.slave  io
);
    localparam int HALF = SHAMT_WIDTH / 2;

    // Applies the shift bits of one stage; bit i of amt shifts by 2**(base+i).
    // With rot set, bits leaving the MSB wrap around to the LSB.
    function automatic logic [OPERAND_WIDTH-1:0] stage_shift(
        input logic [OPERAND_WIDTH-1:0] x,
        input logic [HALF-1:0]          amt,
        input int                       base,
        input logic                     rot
    );
        logic [OPERAND_WIDTH-1:0] r;
        int                       k;
        r = x;
        for (int i = 0; i < HALF; i++) begin
            k = 1 << (base + i);
            if (amt[i]) begin
                if (rot) r = (r << k) | (r >> (OPERAND_WIDTH - k));
                else     r = r << k;
            end
        end
        return r;
    endfunction

    logic                     s1_valid;
    logic [OPERAND_WIDTH-1:0] s1_dat;
    logic [HALF-1:0]          s1_shamt_hi;
    logic                     s2_valid;
    logic [OPERAND_WIDTH-1:0] s2_dat;
    logic                     s1_adv;
    logic                     s2_adv;
    logic                     in_rot;
    logic                     s1_rot_q;
    logic [OPERAND_WIDTH-1:0] s1_nxt;
    logic [OPERAND_WIDTH-1:0] s2_nxt;

    // A stage may take new data when it is empty or its content moves on this cycle.
    assign s2_adv     = !s2_valid || io.OutReady;
    assign s1_adv     = !s1_valid || s2_adv;
    // Held low during reset so nothing is accepted into a pipe being cleared.
    assign io.InReady = s1_adv && !rst;

`ifdef SLL_PIPE_ROT_EN
    assign in_rot = io.Rot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rot_q <= 1'b0;
        end else if (s1_adv && io.InValid) begin
            s1_rot_q <= io.Rot;
        end
    end
`else
    assign in_rot   = 1'b0;
    assign s1_rot_q = 1'b0;
`endif

    assign s1_nxt = stage_shift(io.InBS, io.ShAmt[HALF-1:0], 0, in_rot);
    assign s2_nxt = stage_shift(s1_dat, s1_shamt_hi, HALF, s1_rot_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_dat      <= '0;
            s1_shamt_hi <= '0;
            s2_valid    <= 1'b0;
            s2_dat      <= '0;
        end else begin
            // An idle input while s1 advances leaves a bubble behind.
            if (s1_adv) begin
                s1_valid <= io.InValid;
                if (io.InValid) begin
                    s1_dat      <= s1_nxt;
                    s1_shamt_hi <= io.ShAmt[SHAMT_WIDTH-1:HALF];
                end
            end
            // Result data is only replaced by a real operand, so OutBS holds across bubbles.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_dat <= s2_nxt;
                end
            end
        end
    end

    assign io.OutBS    = s2_dat;
    assign io.OutValid = s2_valid;
endmodule

// File: tb/tb_sll_pipe.sv
// Purpose : self-checking bench for sll_pipe: vector table, directed stall/reset sequences, random traffic.
// Latency : expects results 2 cycles after the accepting cycle when not stalled.
// Backpressure: a queue model predicts InReady, OutValid, ordering and hold-while-stalled.
module tb_sll_pipe;
    localparam int W = 16;
    localparam int S = 4;
`ifdef SLL_PIPE_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    sll_pipe_if #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(S)) io ();

    sll_pipe #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(S)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic         r;
        logic [W-1:0] e;
    } vec_t;

    typedef struct {
        logic [W-1:0] e;
        int           acc;
    } item_t;

    typedef struct {
        logic [W-1:0] bs;
        int           c;
    } obs_t;

    item_t        q[$];
    obs_t         obs[$];
    vec_t         vt[$];
    int           n_chk;
    int           n_fail;
    int           cyc;
    logic         last_in;
    logic         hold_pend;
    logic [W-1:0] held_bs;
    logic         rot_cur;

    // Reference: shift the zero-extended operand in a wide word; rotation ORs back the overflow.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic r);
        logic [31:0] w;
        w = {16'b0, d} << s;
        if (r) w = w | ({16'b0, d} >> (W - s));
        return w[W-1:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [W-1:0] d, input logic [S-1:0] s, input logic r);
        io.InValid = v;
        io.InBS    = d;
        io.ShAmt   = s;
        rot_cur    = r;
`ifdef SLL_PIPE_ROT_EN
        io.Rot     = r;
`endif
    endtask

    // One clock cycle: sample at the falling edge, update the model, return just after the rising edge.
    task automatic step();
        logic exp_rdy;
        logic exp_ov;
        @(negedge clk);
        exp_rdy = !(q.size() == 2 && !io.OutReady);
        check("in_ready", {31'b0, io.InReady}, {31'b0, exp_rdy});
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("out_valid", {31'b0, io.OutValid}, {31'b0, exp_ov});
        if (hold_pend) check("out_hold", {16'b0, io.OutBS}, {16'b0, held_bs});
        last_in = io.InValid && io.InReady;
        if (io.OutValid && io.OutReady) begin
            if (q.size() > 0) begin
                check("out_data", {16'b0, io.OutBS}, {16'b0, q[0].e});
                void'(q.pop_front());
            end else begin
                check("out_spurious", {31'b0, io.OutValid}, 32'd0);
            end
            obs.push_back('{io.OutBS, cyc});
        end
        hold_pend = io.OutValid && !io.OutReady;
        held_bs   = io.OutBS;
        if (last_in) q.push_back('{ref_shift(io.InBS, int'(io.ShAmt), ROT_EN && rot_cur), cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        n_chk = 0; n_fail = 0; cyc = 0;
        last_in = 1'b0; hold_pend = 1'b0; held_bs = '0;
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b0);
        io.OutReady = 1'b1;

        // Vector table: fixed cases then a ShAmt sweep on 0xFFFF.
        vt.push_back('{16'h0001, 4'd15, 1'b0, 16'h8000});
        vt.push_back('{16'hABCD, 4'd4,  1'b0, 16'hBCD0});
        vt.push_back('{16'h1234, 4'd0,  1'b0, 16'h1234});
        vt.push_back('{16'hFFFF, 4'd8,  1'b0, 16'hFF00});
        vt.push_back('{16'h8001, 4'd1,  1'b0, 16'h0002});
        vt.push_back('{16'h0F0F, 4'd7,  1'b0, 16'h8780});
`ifdef SLL_PIPE_ROT_EN
        vt.push_back('{16'h8001, 4'd1,  1'b1, 16'h0003});
        vt.push_back('{16'h8001, 4'd15, 1'b1, 16'hC000});
        vt.push_back('{16'h1234, 4'd4,  1'b1, 16'h2341});
`endif
        for (int s = 0; s < 16; s++) begin
            logic [31:0] full;
            full = 32'h0000FFFF << s;
            vt.push_back('{16'hFFFF, s[S-1:0], 1'b0, full[W-1:0]});
        end

        // Reset state.
        #1;
        check("rst_out_valid", {31'b0, io.OutValid}, 32'd0);
        check("rst_out_bs", {16'b0, io.OutBS}, 32'd0);
        check("rst_in_ready", {31'b0, io.InReady}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven single operands.
        foreach (vt[i]) begin
            obs.delete();
            io.OutReady = 1'b1;
            set_in(1'b1, vt[i].d, vt[i].s, vt[i].r);
            step();
            check("vec_accept", {31'b0, last_in}, 32'd1);
            acc = cyc - 1;
            set_in(1'b0, '0, '0, 1'b0);
            for (int k = 0; k < 6 && obs.size() == 0; k++) step();
            check("vec_seen", obs.size(), 32'd1);
            if (obs.size() > 0) begin
                check("vec_data", {16'b0, obs[0].bs}, {16'b0, vt[i].e});
                check("vec_latency", obs[0].c - acc, 32'd2);
            end
        end

        // Back-to-back operands come out on consecutive cycles.
        obs.delete();
        set_in(1'b1, 16'hABCD, 4'd4, 1'b0);
        step();
        set_in(1'b1, 16'h1234, 4'd0, 1'b0);
        step();
        set_in(1'b0, '0, '0, 1'b0);
        repeat (4) step();
        check("b2b_count", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            check("b2b_first", {16'b0, obs[0].bs}, 32'h0000BCD0);
            check("b2b_second", {16'b0, obs[1].bs}, 32'h00001234);
            check("b2b_spacing", obs[1].c - obs[0].c, 32'd1);
        end

        // Stall: fill both stages, third operand must wait, then drain in order.
        obs.delete();
        io.OutReady = 1'b0;
        n = 0;
        for (int k = 0; k < 10 && n < 2; k++) begin
            set_in(1'b1, 16'h1111 * (n + 1), n[S-1:0], 1'b0);
            step();
            if (last_in) n++;
        end
        check("stall_two_in", n, 32'd2);
        set_in(1'b1, 16'h3333, 4'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_blocked", {31'b0, last_in}, 32'd0);
        end
        io.OutReady = 1'b1;
        last_in = 1'b0;
        for (int k = 0; k < 10 && !last_in; k++) step();
        set_in(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 10 && obs.size() < 3; k++) step();
        check("stall_count", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            check("stall_r0", {16'b0, obs[0].bs}, 32'h00001111);
            check("stall_r1", {16'b0, obs[1].bs}, 32'h00004444);
            check("stall_r2", {16'b0, obs[2].bs}, 32'h0000CCCC);
        end

        // Random traffic against the queue model.
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom % 4) != 0, W'($urandom), S'($urandom), ROT_EN && ($urandom % 2 == 1));
            io.OutReady = ($urandom % 3) != 0;
            step();
        end
        set_in(1'b0, '0, '0, 1'b0);
        io.OutReady = 1'b1;
        repeat (5) step();
        check("drain_empty", q.size(), 32'd0);

        // Asynchronous reset with two operands in flight.
        io.OutReady = 1'b0;
        set_in(1'b1, 16'h00FF, 4'd3, 1'b0);
        step();
        set_in(1'b1, 16'h0F00, 4'd1, 1'b0);
        step();
        set_in(1'b0, '0, '0, 1'b0);
        check("pre_rst_full", q.size(), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, io.OutValid}, 32'd0);
        check("arst_out_bs", {16'b0, io.OutBS}, 32'd0);
        check("arst_in_ready", {31'b0, io.InReady}, 32'd0);
        q.delete();
        obs.delete();
        hold_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        io.OutReady = 1'b1;
        step();
        check("post_rst_ready", {31'b0, io.InReady}, 32'd1);
        repeat (4) step();
        check("post_rst_no_stale", obs.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
